// File: rtl/lab3_mem_refill_arbiter_pkg.sv
// Shared memory message types for the 16B refill path, plus a tiny
// line-trace helper encoding FSM state and granted requester as two ASCII chars.
package lab3_mem_refill_arbiter_pkg;

   typedef struct packed {
      logic [2:0]   mtype;
      logic [7:0]   opaque;
      logic [31:0]  addr;
      logic [3:0]   len;
      logic [127:0] data;
   } mem_req_16B_t;

   typedef struct packed {
      logic [2:0]   mtype;
      logic [7:0]   opaque;
      logic [1:0]   test;
      logic [3:0]   len;
      logic [127:0] data;
   } mem_resp_16B_t;

   // "I0", "S1", "W0" ... for waveform/trace viewers
   function automatic logic [15:0] line_trace(input logic [1:0] st, input logic grant);
      logic [15:0] t;
      t[15:8] = (st == 2'd0) ? 8'h49 : (st == 2'd1) ? 8'h53 : 8'h57;
      t[7:0]  = grant ? 8'h31 : 8'h30;
      return t;
   endfunction

endpackage

// File: rtl/lab3_mem_rr_arb2.sv
// Two-way arbiter: combinational winner select with a priority pointer register
// that the owner advances when a transaction completes.
module lab3_mem_rr_arb2 #(
   parameter bit p_rr = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic req0_val,
   input  logic req1_val,
   input  logic ptr_upd,
   input  logic last_grant,
   output logic winner
);

   logic ptr;

   // Pointer moves to the requester that was not just served.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       ptr <= 1'b0;
      else if (ptr_upd) ptr <= ~last_grant;
   end

   always_comb begin
      winner = 1'b0;
      if (req0_val && req1_val) winner = p_rr ? ptr : 1'b0;
      else if (req1_val)        winner = 1'b1;
   end

endmodule

// File: rtl/lab3_mem_refill_arbiter.sv
// Shares one 16B memory port between two blocking caches with a single
// outstanding transaction; request and response paths add no latency.
module lab3_mem_refill_arbiter
   import lab3_mem_refill_arbiter_pkg::*;
#(
   parameter bit p_rr = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  mem_req_16B_t  req0_msg,
   input  logic          req0_val,
   output logic          req0_rdy,
   input  mem_req_16B_t  req1_msg,
   input  logic          req1_val,
   output logic          req1_rdy,
   output mem_resp_16B_t resp0_msg,
   output logic          resp0_val,
   input  logic          resp0_rdy,
   output mem_resp_16B_t resp1_msg,
   output logic          resp1_val,
   input  logic          resp1_rdy,
   output mem_req_16B_t  memreq_msg,
   output logic          memreq_val,
   input  logic          memreq_rdy,
   input  mem_resp_16B_t memresp_msg,
   input  logic          memresp_val,
   output logic          memresp_rdy,
   output logic [15:0]   grant_cnt0,
   output logic [15:0]   grant_cnt1
);

   typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT = 2'd2} state_t;

   state_t state, state_nxt;
   logic   grant_reg, grant_nxt;
   logic   winner, sel, active;
   logic   memreq_fire, memresp_fire;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   lab3_mem_rr_arb2 #(.p_rr(p_rr)) u_arb (
      .clk        (clk),
      .reset      (reset),
      .req0_val   (req0_val),
      .req1_val   (req1_val),
      .ptr_upd    (memresp_fire),
      .last_grant (grant_reg),
      .winner     (winner)
   );

   // Handshake outputs stay quiet until the first edge after reset release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         grant_reg  <= 1'b0;
         active     <= 1'b0;
         grant_cnt0 <= 16'd0;
         grant_cnt1 <= 16'd0;
      end else begin
         state     <= state_nxt;
         grant_reg <= grant_nxt;
         active    <= 1'b1;
         if (memreq_fire && !sel) grant_cnt0 <= sat_inc(grant_cnt0);
         if (memreq_fire &&  sel) grant_cnt1 <= sat_inc(grant_cnt1);
      end
   end

   always_comb begin
      state_nxt   = state;
      grant_nxt   = grant_reg;
      sel         = grant_reg;
      memreq_val  = 1'b0;
      req0_rdy    = 1'b0;
      req1_rdy    = 1'b0;
      resp0_val   = 1'b0;
      resp1_val   = 1'b0;
      memresp_rdy = 1'b0;
      unique case (state)
         IDLE: begin
            sel        = winner;
            memreq_val = req0_val | req1_val;
            if (memreq_val) begin
               grant_nxt = winner;
               state_nxt = memreq_rdy ? WAIT : SEND;
            end
         end
         SEND: begin
            memreq_val = grant_reg ? req1_val : req0_val;
            if (memreq_val && memreq_rdy) state_nxt = WAIT;
         end
         WAIT: begin
            resp0_val   = memresp_val & ~grant_reg;
            resp1_val   = memresp_val &  grant_reg;
            memresp_rdy = grant_reg ? resp1_rdy : resp0_rdy;
            if (memresp_val && memresp_rdy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (state != WAIT) begin
         req0_rdy = ~sel & memreq_rdy;
         req1_rdy =  sel & memreq_rdy;
      end
      if (!active) begin
         memreq_val  = 1'b0;
         req0_rdy    = 1'b0;
         req1_rdy    = 1'b0;
         resp0_val   = 1'b0;
         resp1_val   = 1'b0;
         memresp_rdy = 1'b0;
      end
   end

   assign memreq_msg   = sel ? req1_msg : req0_msg;
   assign resp0_msg    = memresp_msg;
   assign resp1_msg    = memresp_msg;
   assign memreq_fire  = memreq_val & memreq_rdy;
   assign memresp_fire = memresp_val & memresp_rdy;

endmodule

// File: tb/tb_lab3_mem_refill_arbiter.sv
// Scoreboard bench: two arbiter instances (round-robin and fixed priority) share
// stimulus; a monitor checks every memreq/resp fire against queued expectations.
`timescale 1ns/1ps
module tb_lab3_mem_refill_arbiter;
   import lab3_mem_refill_arbiter_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mem_req_16B_t  req0_msg, req1_msg;
   mem_resp_16B_t memresp_msg;
   logic req0_val, req1_val, resp0_rdy, resp1_rdy, memreq_rdy, memresp_val;

   logic          r0_rdy [2];
   logic          r1_rdy [2];
   logic          s0_val [2];
   logic          s1_val [2];
   logic          mq_val [2];
   logic          ms_rdy [2];
   mem_req_16B_t  mq_msg [2];
   mem_resp_16B_t s0_msg [2];
   mem_resp_16B_t s1_msg [2];
   logic [15:0]   c0 [2];
   logic [15:0]   c1 [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      lab3_mem_refill_arbiter #(.p_rr(g == 0)) dut (
         .clk(clk), .reset(reset),
         .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(r0_rdy[g]),
         .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(r1_rdy[g]),
         .resp0_msg(s0_msg[g]), .resp0_val(s0_val[g]), .resp0_rdy(resp0_rdy),
         .resp1_msg(s1_msg[g]), .resp1_val(s1_val[g]), .resp1_rdy(resp1_rdy),
         .memreq_msg(mq_msg[g]), .memreq_val(mq_val[g]), .memreq_rdy(memreq_rdy),
         .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(ms_rdy[g]),
         .grant_cnt0(c0[g]), .grant_cnt1(c1[g])
      );
   end

   // dsel picks which instance is observed: 0 = round-robin, 1 = fixed priority
   logic dsel = 1'b0;
   logic m_r0, m_r1, m_s0, m_s1, m_mq, m_ms;
   mem_req_16B_t  m_mq_msg;
   mem_resp_16B_t m_s0_msg, m_s1_msg;
   logic [15:0]   m_c0, m_c1;
   assign m_r0 = r0_rdy[dsel];
   assign m_r1 = r1_rdy[dsel];
   assign m_s0 = s0_val[dsel];
   assign m_s1 = s1_val[dsel];
   assign m_mq = mq_val[dsel];
   assign m_ms = ms_rdy[dsel];
   assign m_mq_msg = mq_msg[dsel];
   assign m_s0_msg = s0_msg[dsel];
   assign m_s1_msg = s1_msg[dsel];
   assign m_c0 = c0[dsel];
   assign m_c1 = c1[dsel];

   int errors = 0;
   int checks = 0;
   logic saw_r1 = 1'b0;
   mem_req_16B_t  exp_mq [$];
   mem_resp_16B_t exp_s0 [$];
   mem_resp_16B_t exp_s1 [$];

   task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic mem_req_16B_t mk_req(input logic id, input int n);
      mem_req_16B_t r;
      r.mtype  = n[0] ? 3'd1 : 3'd0;
      r.opaque = {id, 7'(n)};
      r.addr   = 32'h1000 + (id ? 32'h100 : 32'h0) + 32'(n) * 32'd16;
      r.len    = 4'd0;
      r.data   = {4{32'hC0DE0000 | 32'(n)}};
      return r;
   endfunction

   function automatic mem_resp_16B_t mk_resp(input mem_req_16B_t q);
      mem_resp_16B_t s;
      s.mtype  = q.mtype;
      s.opaque = q.opaque;
      s.test   = 2'd0;
      s.len    = 4'd0;
      s.data   = {32'hDEADBEEF, q.addr, ~q.addr, 32'h0BADF00D};
      return s;
   endfunction

   // Monitor: pops an expectation on every fire seen by the observed instance.
   always @(negedge clk) begin
      if (reset) begin
         if (m_r1) saw_r1 = 1'b1;
         if (m_mq && memreq_rdy) begin
            if (exp_mq.size() == 0) chk("memreq_unexpected", 192'(m_mq_msg), 192'h0);
            else chk("memreq_msg", 192'(m_mq_msg), 192'(exp_mq.pop_front()));
         end
         if (m_s0 && resp0_rdy) begin
            if (exp_s0.size() == 0) chk("resp0_unexpected", 192'(m_s0_msg), 192'h0);
            else chk("resp0_msg", 192'(m_s0_msg), 192'(exp_s0.pop_front()));
         end
         if (m_s1 && resp1_rdy) begin
            if (exp_s1.size() == 0) chk("resp1_unexpected", 192'(m_s1_msg), 192'h0);
            else chk("resp1_msg", 192'(m_s1_msg), 192'(exp_s1.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      req0_val = 1'b0; req1_val = 1'b0; memreq_rdy = 1'b0; memresp_val = 1'b0;
      resp0_rdy = 1'b0; resp1_rdy = 1'b0;
      req0_msg = '0; req1_msg = '0; memresp_msg = '0;
   endtask

   task automatic reset_dut();
      reset = 1'b0;
      clear_inputs();
      tick(); tick();
      reset = 1'b1;
      tick();
   endtask

   // One full transaction from IDLE: expected winner id, with memreq_rdy=1.
   task automatic serve(input logic id, input mem_req_16B_t r);
      exp_mq.push_back(r);
      if (id) exp_s1.push_back(mk_resp(r));
      else    exp_s0.push_back(mk_resp(r));
      memreq_rdy = 1'b1;
      settle();
      chk("memreq_val", m_mq, 1'b1);
      chk("win_rdy", id ? m_r1 : m_r0, 1'b1);
      chk("lose_rdy", id ? m_r0 : m_r1, 1'b0);
      tick();
      memresp_msg = mk_resp(r); memresp_val = 1'b1;
      resp0_rdy = 1'b1; resp1_rdy = 1'b1;
      settle();
      chk("resp_fwd_val", id ? m_s1 : m_s0, 1'b1);
      chk("resp_other_val", id ? m_s0 : m_s1, 1'b0);
      chk("wait_req_rdy", {m_r0, m_r1}, 2'b00);
      chk("memresp_rdy", m_ms, 1'b1);
      tick();
      memresp_val = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      mem_req_16B_t r;
      int k0, k1;
      // ---- reset state with every input asserted
      clear_inputs();
      req0_val = 1'b1; req1_val = 1'b1; memreq_rdy = 1'b1; memresp_val = 1'b1;
      resp0_rdy = 1'b1; resp1_rdy = 1'b1;
      tick(); tick();
      chk("rst_req0_rdy", m_r0, 1'b0);
      chk("rst_req1_rdy", m_r1, 1'b0);
      chk("rst_memreq_val", m_mq, 1'b0);
      chk("rst_memresp_rdy", m_ms, 1'b0);
      chk("rst_resp_val", {m_s0, m_s1}, 2'b00);
      chk("rst_cnt", {m_c0, m_c1}, 32'h0);
      chk("rst_memreq_msg_known", $isunknown(m_mq_msg), 1'b0);
      clear_inputs();
      reset = 1'b1;
      tick();

      // ---- single requester, zero-bubble
      req0_val = 1'b1; req0_msg = mk_req(1'b0, 0);
      serve(1'b0, req0_msg);
      req0_val = 1'b0;
      settle();
      chk("single_cnt0", m_c0, 16'd1);
      chk("single_cnt1", m_c1, 16'd0);

      // ---- round-robin fairness
      reset_dut();
      k0 = 1; k1 = 1;
      req0_val = 1'b1; req1_val = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req0_msg = mk_req(1'b0, k0);
         req1_msg = mk_req(1'b1, k1);
         if (i % 2 == 0) begin serve(1'b0, req0_msg); k0++; end
         else            begin serve(1'b1, req1_msg); k1++; end
      end
      req0_val = 1'b0; req1_val = 1'b0;
      settle();
      chk("rr_cnt0", m_c0, 16'd2);
      chk("rr_cnt1", m_c1, 16'd2);

      // ---- fixed priority
      dsel = 1'b1;
      reset_dut();
      saw_r1 = 1'b0;
      req0_val = 1'b1; req1_val = 1'b1; req1_msg = mk_req(1'b1, 5);
      for (int i = 0; i < 3; i++) begin
         req0_msg = mk_req(1'b0, 5 + i);
         serve(1'b0, req0_msg);
      end
      req0_val = 1'b0; req1_val = 1'b0;
      settle();
      chk("fp_req1_rdy_never", saw_r1, 1'b0);
      chk("fp_cnt0", m_c0, 16'd3);
      chk("fp_cnt1", m_c1, 16'd0);
      dsel = 1'b0;

      // ---- backpressure and lock on req1
      reset_dut();
      r = mk_req(1'b1, 10);
      req1_msg = r; req1_val = 1'b1; req0_msg = mk_req(1'b0, 10);
      for (int c = 0; c < 3; c++) begin
         if (c == 1) req0_val = 1'b1;
         settle();
         chk("bp_memreq_val", m_mq, 1'b1);
         chk("bp_memreq_addr", m_mq_msg.addr, r.addr);
         chk("bp_rdy", {m_r0, m_r1}, 2'b00);
         tick();
      end
      memreq_rdy = 1'b1;
      exp_mq.push_back(r); exp_s1.push_back(mk_resp(r));
      settle();
      chk("bp_lock_rdy", {m_r0, m_r1}, 2'b01);
      tick();
      req1_val = 1'b0;
      memresp_msg = mk_resp(r); memresp_val = 1'b1; resp1_rdy = 1'b0; resp0_rdy = 1'b1;
      for (int c = 0; c < 2; c++) begin
         settle();
         chk("bp_memresp_rdy_low", m_ms, 1'b0);
         chk("bp_resp_held", {m_s0, m_s1}, 2'b01);
         chk("bp_req0_rdy", m_r0, 1'b0);
         tick();
      end
      resp1_rdy = 1'b1;
      settle();
      chk("bp_memresp_rdy_high", m_ms, 1'b1);
      tick();
      memresp_val = 1'b0; req0_val = 1'b0;
      settle();
      chk("bp_cnt", {m_c0, m_c1}, {16'd0, 16'd1});

      // ---- reset mid-transaction; pointer returns to req0
      req0_val = 1'b1; req0_msg = mk_req(1'b0, 20);
      serve(1'b0, req0_msg);
      r = mk_req(1'b0, 21);
      req0_msg = r;
      exp_mq.push_back(r);
      settle();
      tick();
      req0_val = 1'b0;
      memresp_msg = mk_resp(r); memresp_val = 1'b1; resp0_rdy = 1'b0;
      settle();
      chk("mid_wait_resp0_val", m_s0, 1'b1);
      reset = 1'b0;
      settle();
      chk("mid_rst_resp_val", {m_s0, m_s1}, 2'b00);
      chk("mid_rst_memresp_rdy", m_ms, 1'b0);
      chk("mid_rst_cnt", {m_c0, m_c1}, 32'h0);
      tick();
      reset = 1'b1; resp0_rdy = 1'b1;
      tick();
      chk("stray_resp0_val", m_s0, 1'b0);
      chk("stray_memresp_rdy", m_ms, 1'b0);
      memresp_val = 1'b0;
      req0_val = 1'b1; req1_val = 1'b1;
      req0_msg = mk_req(1'b0, 22); req1_msg = mk_req(1'b1, 22);
      serve(1'b0, req0_msg);
      serve(1'b1, req1_msg);
      req0_val = 1'b0; req1_val = 1'b0;
      settle();
      chk("post_rst_cnt", {m_c0, m_c1}, {16'd1, 16'd1});

      tick(); tick();
      chk("exp_mq_drained", 192'(exp_mq.size()), 192'd0);
      chk("exp_s0_drained", 192'(exp_s0.size()), 192'd0);
      chk("exp_s1_drained", 192'(exp_s1.size()), 192'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
